// File: rtl/line_clear_flash_ctrl_pkg.sv
// tetris_pkg: shared playfield geometry and line-clear flash FSM state encoding
package tetris_pkg;
    localparam int PF_ROWS  = 20;
    localparam int PF_COLS  = 10;
    localparam int PF_CELLS = PF_ROWS * PF_COLS;
    typedef enum logic [1:0] {IDLE, ON, OFF, DONE} flash_state_t;
endpackage

// File: rtl/line_clear_flash_ctrl_if.sv
// line_clear_flash_ctrl_if: game-logic <-> flash controller bundle
// master (game/display side) drives vs, start, rows_full, abort; slave (controller) drives flash, clear_rows, busy, done
interface line_clear_flash_ctrl_if;
    import tetris_pkg::*;
    logic                vs;
    logic                start;
    logic [PF_ROWS-1:0]  rows_full;
    logic                abort;
    logic [PF_CELLS-1:0] flash;
    logic [PF_ROWS-1:0]  clear_rows;
    logic                busy;
    logic                done;
    modport master (output vs, start, rows_full, abort, input flash, clear_rows, busy, done);
    modport slave  (input vs, start, rows_full, abort, output flash, clear_rows, busy, done);
endinterface

// File: rtl/line_clear_flash_ctrl_frame_tick_gen.sv
// frame_tick_gen: one-cycle frame tick on the falling edge of active-low vs
// ports: clk, clrn (async active-low reset), vs (vertical sync), tick (combinational edge strobe)
module frame_tick_gen (
    input  logic clk,
    input  logic clrn,
    input  logic vs,
    output logic tick
);
    logic vs_q;
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) vs_q <= 1'b1;
        else       vs_q <= vs;
    end
    assign tick = vs_q & ~vs;
endmodule

// File: rtl/line_clear_flash_ctrl.sv
// line_clear_flash_ctrl: latches full rows and blinks them on the display before collapse
// ports: clk, clrn (async active-low reset), bus (slave modport: vs/start/rows_full/abort in, flash/clear_rows/busy/done out)
module line_clear_flash_ctrl
    import tetris_pkg::*;
#(
    parameter int BLINKS           = 3,
    parameter int FRAMES_PER_PHASE = 8
) (
    input  logic                    clk,
    input  logic                    clrn,
    line_clear_flash_ctrl_if.slave  bus
);
    localparam int FW = $clog2(FRAMES_PER_PHASE + 1);
    localparam int BW = $clog2(BLINKS + 1);
    flash_state_t        state_q, state_d;
    logic [FW-1:0]       frame_q, frame_d;
    logic [BW-1:0]       blink_q, blink_d;
    logic [PF_ROWS-1:0]  rows_q, rows_d;
    logic [PF_CELLS-1:0] flash_q, cells;
    logic                busy_q, done_q, tick, phase_end;
    frame_tick_gen u_tick (.clk(clk), .clrn(clrn), .vs(bus.vs), .tick(tick));
    assign phase_end = tick && (frame_q == FW'(FRAMES_PER_PHASE - 1));
    always_comb begin
        state_d = state_q;
        frame_d = frame_q;
        blink_d = blink_q;
        rows_d  = rows_q;
        case (state_q)
            IDLE: if (bus.start) begin
                rows_d  = bus.rows_full;
                frame_d = '0;
                blink_d = '0;
                state_d = |bus.rows_full ? ON : DONE;
            end
            ON: if (bus.abort) state_d = IDLE;
                else if (tick) begin
                    frame_d = phase_end ? '0 : frame_q + 1'b1;
                    state_d = phase_end ? OFF : ON;
                end
            OFF: if (bus.abort) state_d = IDLE;
                else if (tick) begin
                    frame_d = phase_end ? '0 : frame_q + 1'b1;
                    blink_d = phase_end ? blink_q + 1'b1 : blink_q;
                    state_d = !phase_end ? OFF : (blink_q + 1'b1 == BW'(BLINKS)) ? DONE : ON;
                end
            default: state_d = IDLE;
        endcase
    end
    // Expand the next row mask so flash is valid the cycle after an accepted start
    for (genvar r = 0; r < PF_ROWS; r++) begin : g_row
        assign cells[r*PF_COLS +: PF_COLS] = {PF_COLS{rows_d[r]}};
    end
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q <= IDLE;
            frame_q <= '0;
            blink_q <= '0;
            rows_q  <= '0;
            flash_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            frame_q <= frame_d;
            blink_q <= blink_d;
            rows_q  <= rows_d;
            flash_q <= (state_d == ON) ? cells : '0;
            busy_q  <= state_d != IDLE;
            done_q  <= state_d == DONE;
        end
    end
    assign bus.flash      = flash_q;
    assign bus.clear_rows = rows_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
endmodule

// File: tb/tb_line_clear_flash_ctrl.sv
// tb_line_clear_flash_ctrl: directed self-checking bench for line_clear_flash_ctrl (BLINKS=2, FRAMES_PER_PHASE=2)
module tb_line_clear_flash_ctrl;
    logic clk = 1'b0;
    logic clrn = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   ph = 0;
    logic seen_done, seen_flash;
    localparam logic [199:0] NOM  = {10'h3FF, 180'd0, 10'h3FF};
    localparam logic [199:0] ROW0 = {190'd0, 10'h3FF};
    localparam logic [199:0] ROW10 = {90'd0, 10'h3FF, 100'd0};
    logic [7:0] on_pat = 8'b0001_1001;
    line_clear_flash_ctrl_if bus ();
    line_clear_flash_ctrl #(.BLINKS(2), .FRAMES_PER_PHASE(2)) dut (.clk(clk), .clrn(clrn), .bus(bus));
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [199:0] obs, input logic [199:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // vs is low for one cycle in every 20
    task automatic step();
        @(posedge clk);
        #1;
        ph = (ph == 19) ? 0 : ph + 1;
        bus.vs = (ph != 0);
    endtask

    // advance until the edge that consumes the next vs falling edge has happened
    task automatic tick_edge();
        for (int i = 0; i < 25 && bus.vs; i++) step();
        step();
    endtask

    task automatic go(input logic [19:0] m, input logic ab);
        bus.start = 1'b1;
        bus.rows_full = m;
        bus.abort = ab;
        step();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.rows_full = 20'hFFFFF;
    endtask

    task automatic run_ticks(input int from, input logic [199:0] pat, input logic [19:0] m);
        for (int k = from; k <= 8; k++) begin
            tick_edge();
            chk($sformatf("tick%0d flash", k), bus.flash, on_pat[k-1] ? pat : '0);
            chk($sformatf("tick%0d done", k), {199'd0, bus.done}, {199'd0, k == 8});
            chk($sformatf("tick%0d busy", k), {199'd0, bus.busy}, 200'd1);
        end
        chk("end clear_rows", {180'd0, bus.clear_rows}, {180'd0, m});
        step();
        chk("post done", {199'd0, bus.done}, 200'd0);
        chk("post busy", {199'd0, bus.busy}, 200'd0);
    endtask

    task automatic watch200();
        seen_done = 1'b0;
        seen_flash = 1'b0;
        repeat (200) begin
            step();
            if (bus.done) seen_done = 1'b1;
            if (bus.flash != '0) seen_flash = 1'b1;
        end
    endtask

    initial begin
        bus.vs = 1'b1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.rows_full = '0;
        #2;
        chk("rst flash", bus.flash, '0);
        chk("rst busy", {199'd0, bus.busy}, 200'd0);
        chk("rst done", {199'd0, bus.done}, 200'd0);
        chk("rst clear_rows", {180'd0, bus.clear_rows}, 200'd0);
        repeat (3) step();
        @(negedge clk) clrn = 1'b1;
        step();
        // nominal
        if (!bus.vs) step();
        go(20'h80001, 1'b0);
        chk("nom busy", {199'd0, bus.busy}, 200'd1);
        chk("nom flash", bus.flash, NOM);
        chk("nom clear_rows", {180'd0, bus.clear_rows}, {180'd0, 20'h80001});
        run_ticks(1, NOM, 20'h80001);
        // zero mask
        if (!bus.vs) step();
        go(20'h0, 1'b0);
        chk("zero done", {199'd0, bus.done}, 200'd1);
        chk("zero flash", bus.flash, '0);
        chk("zero clear_rows", {180'd0, bus.clear_rows}, 200'd0);
        step();
        chk("zero done T+2", {199'd0, bus.done}, 200'd0);
        chk("zero busy T+2", {199'd0, bus.busy}, 200'd0);
        // start while busy
        if (!bus.vs) step();
        go(20'h80001, 1'b0);
        tick_edge();
        chk("busy tick1 flash", bus.flash, NOM);
        go(20'h00010, 1'b0);
        chk("busy restart clear_rows", {180'd0, bus.clear_rows}, {180'd0, 20'h80001});
        chk("busy restart flash", bus.flash, NOM);
        run_ticks(2, NOM, 20'h80001);
        // start and abort together in IDLE: start wins
        if (!bus.vs) step();
        go(20'h00001, 1'b1);
        chk("start+abort busy", {199'd0, bus.busy}, 200'd1);
        chk("start+abort flash", bus.flash, ROW0);
        // abort during second ON phase (after tick 5)
        for (int k = 1; k <= 5; k++) tick_edge();
        chk("pre-abort flash", bus.flash, ROW0);
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        chk("abort flash", bus.flash, '0);
        chk("abort busy", {199'd0, bus.busy}, 200'd0);
        chk("abort clear_rows", {180'd0, bus.clear_rows}, {180'd0, 20'h00001});
        watch200();
        chk("abort no done", {199'd0, seen_done}, 200'd0);
        chk("abort no flash", {199'd0, seen_flash}, 200'd0);
        // tick coincident with start is not counted
        for (int i = 0; i < 25 && bus.vs; i++) step();
        go(20'h00400, 1'b0);
        chk("coinc flash", bus.flash, ROW10);
        tick_edge();
        chk("coinc tick1 flash", bus.flash, ROW10);
        tick_edge();
        chk("coinc tick2 flash", bus.flash, '0);
        chk("coinc tick2 busy", {199'd0, bus.busy}, 200'd1);
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        // reset mid-sequence during OFF
        if (!bus.vs) step();
        go(20'h80001, 1'b0);
        for (int k = 1; k <= 3; k++) tick_edge();
        chk("pre-reset busy", {199'd0, bus.busy}, 200'd1);
        #3 clrn = 1'b0;
        #1;
        chk("async rst flash", bus.flash, '0);
        chk("async rst busy", {199'd0, bus.busy}, 200'd0);
        chk("async rst clear_rows", {180'd0, bus.clear_rows}, 200'd0);
        chk("async rst done", {199'd0, bus.done}, 200'd0);
        repeat (2) step();
        @(negedge clk) clrn = 1'b1;
        watch200();
        chk("post-rst no done", {199'd0, seen_done}, 200'd0);
        chk("post-rst no flash", {199'd0, seen_flash}, 200'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/line_clear_flash_ctrl.md
# line_clear_flash_ctrl

Sequences the line-clear flash effect on the playfield display. When game logic reports full rows, the block latches the row mask and drives the per-cell flash mask of the VGA display for a fixed number of blink periods. Blink periods are timed by frame ticks derived from `vs`. When the sequence finishes it pulses `done` so game logic can collapse the rows. It sits between the game-state logic and the display datapath, which consumes `flash` as its per-cell flash enable.

## Interface
- `BLINKS`, default 3: number of ON/OFF blink pairs; must be ≥1.
- `FRAMES_PER_PHASE`, default 8: frame ticks per ON or OFF phase; must be ≥1.
- `clk`  in  1  pixel clock (25 MHz); the block's only clock.
- `clrn`  in  1  asynchronous, active-low reset.
- `vs`  in  1  vertical sync from the VGA controller, active-low.
- `start`  in  1  single-cycle request to begin a flash sequence.
- `rows_full`  in  20  full-row mask; bit r is playfield row r (0 = top). Sampled only on an accepted `start`.
- `abort`  in  1  cancels the sequence immediately.
- `flash`  out  200  per-cell flash enable; bit index is row*10+col.
- `clear_rows`  out  20  latched row mask; held stable until the next accepted `start`.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  single-cycle completion pulse.

## Operation
- States: IDLE, ON, OFF, DONE.
- Frame tick:
  - `vs_q` is `vs` registered; `vs_q` resets to 1.
  - `tick = vs_q & ~vs`, i.e. the falling edge of `vs`, seen combinationally in the same cycle.
- IDLE:
  - `start` with `rows_full != 0`: latch `clear_rows <= rows_full`, clear `frame_cnt` and `blink_cnt`, go to ON.
  - `start` with `rows_full == 0`: latch `clear_rows <= 0`, go directly to DONE. No flash is shown.
- ON:
  - `flash` = row mask expanded, i.e. `flash[r*10+c] = clear_rows[r]` for all 10 columns.
  - Each tick increments `frame_cnt`.
  - When a tick arrives with `frame_cnt == FRAMES_PER_PHASE-1`: clear `frame_cnt`, go to OFF.
- OFF:
  - `flash` = 0.
  - Same frame counting as ON.
  - At phase end, increment `blink_cnt`.
  - If the new `blink_cnt == BLINKS`, go to DONE; otherwise go to ON.
- DONE: `done = 1` for exactly one cycle, then unconditionally go to IDLE.
- `start` is ignored while `busy`.
- `abort`, in any non-IDLE state:
  - next state is IDLE, `flash` = 0, no `done` pulse.
  - `clear_rows` keeps its value.
  - `abort` has priority over tick-driven transitions.
- `start` and `abort` asserted together in IDLE: `start` is accepted. `abort` has no effect in IDLE.
- A tick in the same cycle as an accepted `start` is not counted.
- Counter widths:
  - `frame_cnt`: $clog2(FRAMES_PER_PHASE+1) bits.
  - `blink_cnt`: $clog2(BLINKS+1) bits.
  - Neither counter wraps in legal operation.

## Timing
- All outputs are registered.
- Reset values: `flash` = 0, `clear_rows` = 0, `busy` = 0, `done` = 0, state = IDLE, both counters = 0.
- Latency from accepted `start` (cycle T):
  - `busy` = 1 and `flash` valid at T+1.
  - For the zero-mask case, `done` = 1 at T+1.
- Phase changes:
  - A phase-ending tick at cycle T updates `flash` at T+1.
  - `done` rises at T+1 after the final OFF phase's ending tick.
  - `busy` falls at T+2.
- Total flash duration: 2·BLINKS·FRAMES_PER_PHASE ticks, ±1 partial frame at the start.
- `abort` at cycle T: `flash` = 0 and `busy` = 0 at T+1.
- Reset asserted mid-sequence: all outputs clear asynchronously. No `done` pulse follows reset release.

## Structure
- Shared package `tetris_pkg` holds:
  - the state enum `flash_state_t` (IDLE, ON, OFF, DONE);
  - constants `PF_ROWS = 20` and `PF_COLS = 10`;
  - constant `PF_CELLS = 200`.
- `flash` width and row expansion use `PF_ROWS`/`PF_COLS` from `tetris_pkg`, not literals.
- One sub-module, `frame_tick_gen`, holds the `vs` register and falling-edge detect (ports: `clk`, `clrn`, `vs`, `tick`).
- The row-to-cell expansion is a generate loop, not a sub-module.

## Test plan
All scenarios use BLINKS=2, FRAMES_PER_PHASE=2, with `vs` toggled to give one falling edge every 20 cycles.
- Nominal sequence: `start` with `rows_full = 20'h80001` (rows 0 and 19).
  - `flash` bits 0–9 and 190–199 = 1, all other bits 0.
  - Sequence ON, OFF, ON, OFF, with each phase ending at the 2nd counted tick.
  - `done` is a 1-cycle pulse after the 8th counted tick; `clear_rows = 20'h80001`.
- Zero mask: `start` with `rows_full = 0`.
  - `done` = 1 at T+1, `flash` stays 0, `busy` = 0 at T+2.
- Start while busy: `start` with `rows_full = 20'h00010` during ON.
  - The second request is ignored; `clear_rows` stays at the original mask.
  - Timing of `done` is unchanged.
- Abort during the second ON phase.
  - Next cycle: `flash` = 0, `busy` = 0.
  - No `done` pulse within the following 200 cycles.
- Tick coincident with `start`: the tick is not counted; the first ON phase ends at the 2nd subsequent tick.
- Reset mid-sequence: `clrn` low during OFF.
  - All outputs clear asynchronously.
  - After release, `flash` stays 0 and no `done` pulse is seen for 200 cycles.
